// File: rtl/uio_arb_pkg.sv
// Shared definitions for the user-I/O request arbiter: tag-field placement
// and the width of the bad-tag counter.
package uio_arb_pkg;

  localparam int BAD_CNT_W = 16;

  // The source ID occupies the top tag_w bits; everything below is payload.
  function automatic int tag_lsb(input int data_w, input int tag_w);
    return data_w - tag_w;
  endfunction

endpackage

// File: rtl/uio_rr_arb.sv
// Round-robin one-hot arbiter: the winner is the first requester that is
// both valid and enabled, searching upward from ptr and wrapping modulo N.
module uio_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vld,
  input  logic [N-1:0]     en,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [N-1:0] elig;

  assign elig = vld & en;

  // NOTE: every output gets a default before the search loop, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_any && elig[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uio_rq_arbiter.sv
// Shares one UIO request/response port pair between NUM_REQ requesters:
// round-robin request issue with source-ID tagging, tag-steered responses.
module uio_rq_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int UIO_PORTS_WIDTH = 128
) (
  input  logic                               clk_per,
  input  logic                               reset_per_n,
  input  logic [NUM_REQ-1:0]                 req_vld,
  input  logic [NUM_REQ*UIO_PORTS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                 req_rdy,
  input  logic [NUM_REQ-1:0]                 req_en,
  output logic                               uio_rq_vld,
  output logic [UIO_PORTS_WIDTH-1:0]         uio_rq_data,
  input  logic                               uio_rq_afull,
  input  logic                               uio_rs_vld,
  input  logic [UIO_PORTS_WIDTH-1:0]         uio_rs_data,
  output logic                               uio_rs_afull,
  output logic [NUM_REQ-1:0]                 req_rs_vld,
  output logic [UIO_PORTS_WIDTH-1:0]         req_rs_data,
  input  logic [NUM_REQ-1:0]                 req_rs_afull,
  output logic [BAD_CNT_W-1:0]               bad_tag_cnt
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int PAY_W = tag_lsb(UIO_PORTS_WIDTH, TAG_W);
  localparam logic [TAG_W:0] NUM_REQ_L = (TAG_W + 1)'(NUM_REQ);

  logic               afull_r;
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] en_eff;
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_idx;
  logic               grant_any;
  logic [PAY_W-1:0]   win_payload;
  logic [TAG_W-1:0]   rs_tag;
  logic [NUM_REQ-1:0] rs_vld_d;
  logic               rs_bad;

  assign en_eff = req_en & {NUM_REQ{~afull_r}};

  uio_rr_arb #(
    .N     (NUM_REQ),
    .IDX_W (TAG_W)
  ) u_arb (
    .vld       (req_vld),
    .en        (en_eff),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Grants are suppressed while reset is held so no requester sees a
  // handshake that the registers cannot capture.
  assign req_rdy  = grant & {NUM_REQ{reset_per_n}};
  assign next_ptr = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);

  always_comb begin
    win_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_payload |= req_data[i*UIO_PORTS_WIDTH +: PAY_W];
    end
  end

  always_comb begin
    rs_tag = uio_rs_data[UIO_PORTS_WIDTH-1 -: TAG_W];
    for (int i = 0; i < NUM_REQ; i++) begin
      rs_vld_d[i] = uio_rs_vld && (rs_tag == TAG_W'(i));
    end
    rs_bad = uio_rs_vld && ({1'b0, rs_tag} >= NUM_REQ_L);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_per or negedge reset_per_n) begin
    if (!reset_per_n) begin
      afull_r      <= 1'b0;
      rr_ptr       <= '0;
      uio_rq_vld   <= 1'b0;
      uio_rq_data  <= '0;
      req_rs_vld   <= '0;
      req_rs_data  <= '0;
      uio_rs_afull <= 1'b0;
      bad_tag_cnt  <= '0;
    end else begin
      afull_r      <= uio_rq_afull;
      uio_rs_afull <= |req_rs_afull;
      uio_rq_vld   <= grant_any;
      if (grant_any) begin
        rr_ptr      <= next_ptr;
        uio_rq_data <= {grant_idx, win_payload};
      end
      req_rs_vld <= rs_vld_d;
      if (uio_rs_vld) req_rs_data <= uio_rs_data;
      if (rs_bad && (bad_tag_cnt != '1)) bad_tag_cnt <= bad_tag_cnt + BAD_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uio_rq_arbiter.sv
// Directed bench for uio_rq_arbiter: a table of arbitration vectors plus
// hand-written afull, response, bad-tag and mid-stream reset sequences.
module tb_uio_rq_arbiter;

  localparam int W  = 128;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]   req_vld, req_rdy, req_en, req_rs_vld, req_rs_afull;
  logic [N*W-1:0] req_data;
  logic           uio_rq_vld, uio_rq_afull, uio_rs_vld, uio_rs_afull;
  logic [W-1:0]   uio_rq_data, uio_rs_data, req_rs_data;
  logic [15:0]    bad_tag_cnt;

  logic [N3-1:0]   d3_req_vld, d3_req_rdy, d3_req_en, d3_req_rs_vld, d3_req_rs_afull;
  logic [N3*W-1:0] d3_req_data;
  logic            d3_uio_rq_vld, d3_uio_rs_vld, d3_uio_rs_afull;
  logic [W-1:0]    d3_uio_rq_data, d3_uio_rs_data, d3_req_rs_data;
  logic [15:0]     d3_bad_tag_cnt;

  uio_rq_arbiter #(.NUM_REQ(N), .UIO_PORTS_WIDTH(W)) dut (
    .clk_per(clk), .reset_per_n(rst_n),
    .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy), .req_en(req_en),
    .uio_rq_vld(uio_rq_vld), .uio_rq_data(uio_rq_data), .uio_rq_afull(uio_rq_afull),
    .uio_rs_vld(uio_rs_vld), .uio_rs_data(uio_rs_data), .uio_rs_afull(uio_rs_afull),
    .req_rs_vld(req_rs_vld), .req_rs_data(req_rs_data), .req_rs_afull(req_rs_afull),
    .bad_tag_cnt(bad_tag_cnt)
  );

  uio_rq_arbiter #(.NUM_REQ(N3), .UIO_PORTS_WIDTH(W)) dut3 (
    .clk_per(clk), .reset_per_n(rst_n),
    .req_vld(d3_req_vld), .req_data(d3_req_data), .req_rdy(d3_req_rdy), .req_en(d3_req_en),
    .uio_rq_vld(d3_uio_rq_vld), .uio_rq_data(d3_uio_rq_data), .uio_rq_afull(1'b0),
    .uio_rs_vld(d3_uio_rs_vld), .uio_rs_data(d3_uio_rs_data), .uio_rs_afull(d3_uio_rs_afull),
    .req_rs_vld(d3_req_rs_vld), .req_rs_data(d3_req_rs_data), .req_rs_afull(d3_req_rs_afull),
    .bad_tag_cnt(d3_bad_tag_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] en;
    logic [N-1:0] exp_rdy;
  } vec_t;

  vec_t         vecs[16];
  int           n_pass = 0;
  int           n_total = 0;
  logic [W-1:0] lanes[N];
  logic [W-1:0] exp_data;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_rq(input int idx);
    logic [W-1:0] v;
    v = lanes[idx];
    v[W-1 -: 2] = 2'(idx);
    return v;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  initial begin
    vecs[0]  = '{4'b1111, 4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b1111, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1111, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b1111, 4'b0001};
    vecs[5]  = '{4'b1010, 4'b1111, 4'b0010};
    vecs[6]  = '{4'b1010, 4'b1111, 4'b1000};
    vecs[7]  = '{4'b1010, 4'b1111, 4'b0010};
    vecs[8]  = '{4'b0000, 4'b1111, 4'b0000};
    vecs[9]  = '{4'b0001, 4'b1111, 4'b0001};
    vecs[10] = '{4'b1111, 4'b0111, 4'b0010};
    vecs[11] = '{4'b1111, 4'b0111, 4'b0100};
    vecs[12] = '{4'b1000, 4'b0111, 4'b0000};
    vecs[13] = '{4'b1000, 4'b1111, 4'b1000};
    vecs[14] = '{4'b1100, 4'b0011, 4'b0000};
    vecs[15] = '{4'b0110, 4'b1111, 4'b0010};

    for (int i = 0; i < N; i++) begin
      lanes[i] = {32{4'(i + 9)}};
      req_data[i*W +: W] = lanes[i];
    end
    req_vld = '0; req_en = '1; uio_rq_afull = 1'b0; uio_rs_vld = 1'b0;
    uio_rs_data = '0; req_rs_afull = '0;
    d3_req_vld = '0; d3_req_en = '1; d3_req_data = '0; d3_uio_rs_vld = 1'b0;
    d3_uio_rs_data = '0; d3_req_rs_afull = '0;
    exp_data = '0;

    // Reset state, with requests already presented.
    req_vld = 4'b1111;
    repeat (2) step();
    check("rst_rdy", W'(req_rdy), '0);
    check("rst_rq_vld", W'(uio_rq_vld), '0);
    check("rst_rq_data", uio_rq_data, '0);
    check("rst_rs_vld", W'(req_rs_vld), '0);
    check("rst_rs_afull", W'(uio_rs_afull), '0);
    check("rst_bad_cnt", W'(bad_tag_cnt), '0);
    rst_n = 1'b1;

    // Arbitration table: one row per cycle, state carried between rows.
    for (int i = 0; i < 16; i++) begin
      req_vld = vecs[i].vld;
      req_en  = vecs[i].en;
      #1;
      check($sformatf("vec%0d_rdy", i), W'(req_rdy), W'(vecs[i].exp_rdy));
      step();
      check($sformatf("vec%0d_rq_vld", i), W'(uio_rq_vld), W'(|vecs[i].exp_rdy));
      if (|vecs[i].exp_rdy) exp_data = exp_rq(oh_idx(vecs[i].exp_rdy));
      check($sformatf("vec%0d_rq_data", i), uio_rq_data, exp_data);
    end

    // Almost-full: raised in cycle N, one more grant in N, none after.
    req_vld = 4'b1111; req_en = 4'b1111; uio_rq_afull = 1'b1;
    #1;
    check("afull_grant_n", W'(req_rdy), W'(4'b0100));
    step();
    check("afull_vld_n1", W'(uio_rq_vld), W'(1));
    check("afull_data_n1", uio_rq_data, exp_rq(2));
    check("afull_rdy_n1", W'(req_rdy), '0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("afull_hold%0d_vld", k), W'(uio_rq_vld), '0);
      check($sformatf("afull_hold%0d_rdy", k), W'(req_rdy), '0);
    end
    uio_rq_afull = 1'b0;
    #1;
    check("afull_fall_rdy", W'(req_rdy), '0);
    step();
    check("afull_fall_vld", W'(uio_rq_vld), '0);
    check("afull_resume_rdy", W'(req_rdy), W'(4'b1000));
    step();
    check("afull_resume_vld", W'(uio_rq_vld), W'(1));
    check("afull_resume_data", uio_rq_data, exp_rq(3));
    req_vld = '0;

    // Responses: steering, back-to-back, hold, and response backpressure.
    uio_rs_vld = 1'b1; uio_rs_data = {16{8'hA5}}; req_rs_afull = 4'b0010;
    step();
    check("rs_tag2_vld", W'(req_rs_vld), W'(4'b0100));
    check("rs_tag2_data", req_rs_data, {16{8'hA5}});
    check("rs_afull_set", W'(uio_rs_afull), W'(1));
    uio_rs_data = {16{8'h5A}}; req_rs_afull = '0;
    step();
    check("rs_tag1_vld", W'(req_rs_vld), W'(4'b0010));
    check("rs_tag1_data", req_rs_data, {16{8'h5A}});
    check("rs_afull_clr", W'(uio_rs_afull), '0);
    uio_rs_vld = 1'b0; uio_rs_data = '0;
    step();
    check("rs_idle_vld", W'(req_rs_vld), '0);
    check("rs_idle_hold", req_rs_data, {16{8'h5A}});
    check("rs_no_bad", W'(bad_tag_cnt), '0);

    // NUM_REQ=3: tag 3 is out of range.
    d3_uio_rs_vld = 1'b1; d3_uio_rs_data = {32{4'hF}};
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bad%0d_vld", k), W'(d3_req_rs_vld), '0);
    end
    d3_uio_rs_data = {32{4'h4}};
    step();
    check("bad_cnt3", W'(d3_bad_tag_cnt), W'(3));
    check("d3_tag1_vld", W'(d3_req_rs_vld), W'(3'b010));
    d3_uio_rs_vld = 1'b0;

    // Reset mid-burst: outputs clear without a clock edge.
    req_vld = 4'b1111; uio_rs_vld = 1'b1; uio_rs_data = {16{8'hA5}};
    d3_uio_rs_vld = 1'b1; d3_uio_rs_data = {32{4'hF}};
    step();
    step();
    check("burst_rq_vld", W'(uio_rq_vld), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rq_vld", W'(uio_rq_vld), '0);
    check("arst_rq_data", uio_rq_data, '0);
    check("arst_rdy", W'(req_rdy), '0);
    check("arst_rs_vld", W'(req_rs_vld), '0);
    check("arst_rs_data", req_rs_data, '0);
    check("arst_d3_bad", W'(d3_bad_tag_cnt), '0);
    uio_rs_vld = 1'b0; d3_uio_rs_vld = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy", W'(req_rdy), W'(4'b0001));
    step();
    check("post_rst_data", uio_rq_data, exp_rq(0));
    req_vld = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
